// File: rtl/axi_dma_lite_seq.sv
// AXI-Lite master sequencer that programs one AXI DMA channel in simple mode,
// waits for completion (interrupt or DMASR polling), then clears the IOC status.
module axi_dma_lite_seq #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  CH_BASE   = 8'h00,
  parameter bit          USE_MSB   = 1'b1,
  parameter bit          POLL_MODE = 1'b0,
  parameter int          LEN_W     = 26,
  parameter logic [23:0] TIMEOUT   = 24'hFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       addr_data,
  input  logic [31:0]       msb_data,
  input  logic [31:0]       length_data,
  input  logic              dma_introut,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [3:0]        dbg_state,
  output logic [ADDR_W-1:0] m_axi_lite_awaddr,
  output logic              m_axi_lite_awvalid,
  input  logic              m_axi_lite_awready,
  output logic [31:0]       m_axi_lite_wdata,
  output logic              m_axi_lite_wvalid,
  input  logic              m_axi_lite_wready,
  input  logic [1:0]        m_axi_lite_bresp,
  input  logic              m_axi_lite_bvalid,
  output logic              m_axi_lite_bready,
  output logic [ADDR_W-1:0] m_axi_lite_araddr,
  output logic              m_axi_lite_arvalid,
  input  logic              m_axi_lite_arready,
  input  logic [31:0]       m_axi_lite_rdata,
  input  logic [1:0]        m_axi_lite_rresp,
  input  logic              m_axi_lite_rvalid,
  output logic              m_axi_lite_rready
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_DMACR = 4'd1,
    WR_ADDR  = 4'd2,
    WR_MSB   = 4'd3,
    WR_LEN   = 4'd4,
    WAIT     = 4'd5,
    RD_SR    = 4'd6,
    WR_SR    = 4'd7,
    FIN      = 4'd8
  } state_t;

  localparam logic [31:0] LEN_MASK = (LEN_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << LEN_W) - 32'd1);
  localparam logic [31:0] SR_DONE_MASK = 32'h0000_1002;  // IOC_Irq | Idle

  state_t      state, state_nxt;
  logic [2:0]  err_code_nxt;
  logic [31:0] addr_q, msb_q, len_q;
  logic        aw_done, w_done, ar_done, rd_gap;
  logic [23:0] tmo_cnt;
  logic        tmo_hit;
  logic        wr_st;
  logic [7:0]  reg_off;
  logic [31:0] wr_data;
  logic        b_fire, r_fire, sr_done;

  // Handshake: a transfer happens on a clock where valid && ready are both high.
  // Each valid is raised on state entry, held with stable payload until its ready
  // is sampled, then dropped; bready/rready stay high for the whole access state.
  always_comb begin
    wr_st   = 1'b1;
    reg_off = 8'h00;
    wr_data = 32'h0;
    case (state)
      WR_DMACR: begin reg_off = 8'h00; wr_data = 32'h0000_1001; end
      WR_ADDR:  begin reg_off = 8'h18; wr_data = addr_q;        end
      WR_MSB:   begin reg_off = 8'h1C; wr_data = msb_q;         end
      WR_LEN:   begin reg_off = 8'h28; wr_data = len_q;         end
      WR_SR:    begin reg_off = 8'h04; wr_data = 32'h0000_1000; end
      default:  wr_st = 1'b0;
    endcase
  end

  assign m_axi_lite_awaddr  = wr_st ? (ADDR_W'(CH_BASE) + ADDR_W'(reg_off)) : '0;
  assign m_axi_lite_wdata   = wr_data;
  assign m_axi_lite_awvalid = wr_st && !aw_done;
  assign m_axi_lite_wvalid  = wr_st && !w_done;
  assign m_axi_lite_bready  = wr_st;
  assign m_axi_lite_araddr  = (state == RD_SR) ? (ADDR_W'(CH_BASE) + ADDR_W'(8'h04)) : '0;
  assign m_axi_lite_arvalid = (state == RD_SR) && !ar_done && !rd_gap;
  assign m_axi_lite_rready  = (state == RD_SR);

  assign busy      = (state != IDLE) && (state != FIN);
  assign done      = (state == FIN);
  assign err       = (state == FIN) && (err_code != 3'd0);
  assign dbg_state = state;

  assign b_fire  = m_axi_lite_bvalid && m_axi_lite_bready;
  assign r_fire  = m_axi_lite_rvalid && m_axi_lite_rready;
  assign sr_done = |(m_axi_lite_rdata & SR_DONE_MASK);
  assign tmo_hit = (TIMEOUT != 24'd0) && (tmo_cnt >= (TIMEOUT - 24'd1));

  always_comb begin
    state_nxt    = state;
    err_code_nxt = err_code;
    case (state)
      IDLE: begin
        if (start) begin
          if ((length_data & LEN_MASK) == 32'h0) begin
            state_nxt    = FIN;
            err_code_nxt = 3'd4;
          end else begin
            state_nxt    = WR_DMACR;
            err_code_nxt = 3'd0;
          end
        end
      end
      WR_DMACR, WR_ADDR, WR_MSB, WR_LEN, WR_SR: begin
        if (b_fire) begin
          if (m_axi_lite_bresp != 2'b00) begin
            state_nxt    = FIN;
            err_code_nxt = 3'd1;
          end else begin
            case (state)
              WR_DMACR: state_nxt = WR_ADDR;
              WR_ADDR:  state_nxt = USE_MSB ? WR_MSB : WR_LEN;
              WR_MSB:   state_nxt = WR_LEN;
              WR_LEN:   state_nxt = WAIT;
              default:  state_nxt = FIN;
            endcase
          end
        end
      end
      WAIT: begin
        if (POLL_MODE) begin
          state_nxt = RD_SR;
        end else if (dma_introut) begin
          state_nxt = WR_SR;
        end else if (tmo_hit) begin
          state_nxt    = FIN;
          err_code_nxt = 3'd3;
        end
      end
      RD_SR: begin
        // A timeout never abandons an issued read; it is only honoured
        // once the response is back or between polls.
        if (r_fire) begin
          if (m_axi_lite_rresp != 2'b00) begin
            state_nxt    = FIN;
            err_code_nxt = 3'd2;
          end else if (sr_done) begin
            state_nxt = WR_SR;
          end else if (tmo_hit) begin
            state_nxt    = FIN;
            err_code_nxt = 3'd3;
          end
        end else if (rd_gap && tmo_hit) begin
          state_nxt    = FIN;
          err_code_nxt = 3'd3;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      err_code <= 3'd0;
      addr_q   <= 32'h0;
      msb_q    <= 32'h0;
      len_q    <= 32'h0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      ar_done  <= 1'b0;
      rd_gap   <= 1'b0;
      tmo_cnt  <= 24'd0;
    end else begin
      state    <= state_nxt;
      err_code <= err_code_nxt;
      if (state == IDLE && start) begin
        addr_q <= addr_data;
        msb_q  <= msb_data;
        len_q  <= length_data & LEN_MASK;
      end
      if (state_nxt != state) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        ar_done <= 1'b0;
        rd_gap  <= 1'b0;
      end else begin
        if (m_axi_lite_awvalid && m_axi_lite_awready) aw_done <= 1'b1;
        if (m_axi_lite_wvalid && m_axi_lite_wready)   w_done  <= 1'b1;
        if (m_axi_lite_arvalid && m_axi_lite_arready) ar_done <= 1'b1;
        // Status not yet complete: idle one cycle, then issue the next poll.
        if (state == RD_SR && r_fire) begin
          ar_done <= 1'b0;
          rd_gap  <= 1'b1;
        end else if (rd_gap) begin
          rd_gap <= 1'b0;
        end
      end
      if (state == WAIT || state == RD_SR) begin
        if (tmo_cnt != 24'hFF_FFFF) tmo_cnt <= tmo_cnt + 24'd1;
      end else begin
        tmo_cnt <= 24'd0;
      end
    end
  end

endmodule
